cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter.sv | 145 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-channel result FIFOs feeding a single registered
// broadcast port, with round-robin selection and ready-based backpressure.
module cdb_arbiter #(
  parameter int N_SRC     = 6,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 4,
  parameter int BUF_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_SRC-1:0]           src_valid,
  output logic [N_SRC-1:0]           src_ready,
  input  logic [N_SRC*TAG_W-1:0]     src_tag,
  input  logic [N_SRC*DATA_W-1:0]    src_data,
  input  logic                       flush,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_data,
  output logic [$clog2(N_SRC)-1:0]   cdb_src,
  output logic [N_SRC-1:0]           pending
);

  localparam int SRC_W   = $clog2(N_SRC);
  localparam int PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam int ENTRY_W = TAG_W + DATA_W;

  localparam logic [SRC_W:0]   N_SRC_EXT = N_SRC[SRC_W:0];
  localparam logic [SRC_W-1:0] LAST_SRC  = SRC_W'(N_SRC - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);

  logic [N_SRC-1:0]              full;
  logic [N_SRC-1:0]              push;
  logic [N_SRC-1:0]              pop;
  logic [N_SRC-1:0]              pending_w;
  logic [N_SRC-1:0][ENTRY_W-1:0] head;

  logic [SRC_W-1:0]   rr_ptr_reg;
  logic [SRC_W-1:0]   rr_ptr_next;
  logic [2*N_SRC-1:0] pend_dbl;
  logic [N_SRC-1:0]   pend_rot;
  logic [SRC_W-1:0]   win_off;
  logic [SRC_W:0]     win_sum;
  logic [SRC_W-1:0]   win_idx;
  logic               win_valid;
  logic [ENTRY_W-1:0] win_entry;

  logic               cdb_valid_reg;
  logic [TAG_W-1:0]   cdb_tag_reg;
  logic [DATA_W-1:0]  cdb_data_reg;
  logic [SRC_W-1:0]   cdb_src_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Ready looks only at registered occupancy, so a full FIFO refuses even when popped.
  assign src_ready = ~full & {N_SRC{~reset}};
  assign pending   = pending_w;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_ch
      logic [ENTRY_W-1:0] mem [BUF_DEPTH];
      logic [PTR_W-1:0]   wrptr_reg;
      logic [PTR_W-1:0]   rdptr_reg;
      logic [CNT_W-1:0]   count_reg;

      assign push[gi] = src_valid[gi] && src_ready[gi] &&
                        (src_tag[gi*TAG_W +: TAG_W] != '0);
      assign pop[gi]  = win_valid && (win_idx == SRC_W'(gi));

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          wrptr_reg <= '0;
          rdptr_reg <= '0;
          count_reg <= '0;
        end else begin
          if (push[gi]) wrptr_reg <= ptr_inc(wrptr_reg);
          if (pop[gi])  rdptr_reg <= ptr_inc(rdptr_reg);
          case ({push[gi], pop[gi]})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (push[gi] && !reset && !flush)
          mem[wrptr_reg] <= {src_tag[gi*TAG_W +: TAG_W], src_data[gi*DATA_W +: DATA_W]};
      end

      assign head[gi]      = mem[rdptr_reg];
      assign full[gi]      = (count_reg == FULL_CNT);
      assign pending_w[gi] = (count_reg != '0);
    end
  endgenerate

  // Rotate pending so bit 0 is the channel at rr_ptr; the lowest set bit wins.
  always_comb begin
    pend_dbl  = {pending_w, pending_w} >> rr_ptr_reg;
    pend_rot  = pend_dbl[N_SRC-1:0];
    win_valid = 1'b0;
    win_off   = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (pend_rot[k]) begin
        win_valid = 1'b1;
        win_off   = SRC_W'(k);
      end
    end
    win_sum     = {1'b0, rr_ptr_reg} + {1'b0, win_off};
    win_idx     = (win_sum >= N_SRC_EXT) ? SRC_W'(win_sum - N_SRC_EXT) : win_sum[SRC_W-1:0];
    rr_ptr_next = (win_idx == LAST_SRC) ? '0 : win_idx + 1'b1;
    win_entry   = head[win_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cdb_valid_reg <= 1'b0;
      cdb_tag_reg   <= '0;
      cdb_data_reg  <= '0;
      cdb_src_reg   <= '0;
      rr_ptr_reg    <= '0;
    end else if (flush) begin
      cdb_valid_reg <= 1'b0;
      rr_ptr_reg    <= '0;
    end else begin
      cdb_valid_reg <= win_valid;
      if (win_valid) begin
        cdb_tag_reg  <= win_entry[ENTRY_W-1:DATA_W];
        cdb_data_reg <= win_entry[DATA_W-1:0];
        cdb_src_reg  <= win_idx;
        rr_ptr_reg   <= rr_ptr_next;
      end
    end
  end

  assign cdb_valid = cdb_valid_reg;
  assign cdb_tag   = cdb_tag_reg;
  assign cdb_data  = cdb_data_reg;
  assign cdb_src   = cdb_src_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: single result, contention, wrap-around,
// backpressure, tag-0 discard, and flush/reset in the middle of traffic.
module tb_cdb_arbiter;
  localparam int N_SRC     = 6;
  localparam int DATA_W    = 32;
  localparam int TAG_W     = 4;
  localparam int BUF_DEPTH = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     flush;
  logic [N_SRC-1:0]         src_valid;
  logic [N_SRC-1:0]         src_ready;
  logic [N_SRC*TAG_W-1:0]   src_tag;
  logic [N_SRC*DATA_W-1:0]  src_data;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [DATA_W-1:0]        cdb_data;
  logic [2:0]               cdb_src;
  logic [N_SRC-1:0]         pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .N_SRC(N_SRC), .DATA_W(DATA_W), .TAG_W(TAG_W), .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_ready(src_ready),
    .src_tag(src_tag), .src_data(src_data), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_src(cdb_src), .pending(pending)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Checks the broadcast port; payload is only compared when a broadcast is expected.
  task automatic chk_cdb(input string name, input logic v, input logic [TAG_W-1:0] t,
                         input logic [DATA_W-1:0] d, input logic [2:0] s);
    $display("cdb %s: valid=%0b tag=%0h data=%0h src=%0d", name, cdb_valid, cdb_tag, cdb_data, cdb_src);
    chk({name, " valid"}, 64'(cdb_valid), 64'(v));
    if (v) begin
      chk({name, " tag"},  64'(cdb_tag),  64'(t));
      chk({name, " data"}, 64'(cdb_data), 64'(d));
      chk({name, " src"},  64'(cdb_src),  64'(s));
    end
  endtask

  task automatic push(input int ch, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    src_valid[ch]                  = 1'b1;
    src_tag[ch*TAG_W +: TAG_W]     = t;
    src_data[ch*DATA_W +: DATA_W]  = d;
  endtask

  task automatic idle();
    src_valid = '0;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    src_valid = '0;
    src_tag   = '0;
    src_data  = '0;

    // Reset state
    tick();
    chk("reset src_ready", 64'(src_ready), 64'h00);
    chk("reset pending",   64'(pending),   64'h00);
    chk("reset cdb_valid", 64'(cdb_valid), 64'h0);
    chk("reset cdb_tag",   64'(cdb_tag),   64'h0);
    chk("reset cdb_data",  64'(cdb_data),  64'h0);
    chk("reset cdb_src",   64'(cdb_src),   64'h0);
    reset = 1'b0;
    #1;
    chk("release src_ready", 64'(src_ready), 64'h3F);

    // Single channel: ch2 tag 5 data 0x1234
    push(2, 4'd5, 32'h1234);
    tick();
    idle();
    chk("single pending", 64'(pending), 64'h04);
    chk_cdb("single E0", 1'b0, 4'd0, 32'h0, 3'd0);
    tick();
    chk_cdb("single E1", 1'b1, 4'd5, 32'h1234, 3'd2);
    chk("single pending E1", 64'(pending), 64'h00);
    tick();
    chk_cdb("single E2", 1'b0, 4'd0, 32'h0, 3'd0);
    chk("single tag hold", 64'(cdb_tag), 64'h5);

    // Flush to bring rr_ptr back to 0, then three-way contention
    flush = 1'b1;
    tick();
    flush = 1'b0;
    push(1, 4'd1, 32'h11);
    push(3, 4'd3, 32'h33);
    push(5, 4'd5, 32'h55);
    tick();
    idle();
    chk("cont pending", 64'(pending), 64'h2A);
    tick();
    chk_cdb("cont 1st", 1'b1, 4'd1, 32'h11, 3'd1);
    tick();
    chk_cdb("cont 2nd", 1'b1, 4'd3, 32'h33, 3'd3);
    tick();
    chk_cdb("cont 3rd", 1'b1, 4'd5, 32'h55, 3'd5);
    tick();
    chk_cdb("cont idle", 1'b0, 4'd0, 32'h0, 3'd0);

    // rr_ptr should be 0: ch0 beats ch5
    push(0, 4'd2, 32'h20);
    push(5, 4'd6, 32'h60);
    tick();
    idle();
    tick();
    chk_cdb("rr0 1st", 1'b1, 4'd2, 32'h20, 3'd0);
    tick();
    chk_cdb("rr0 2nd", 1'b1, 4'd6, 32'h60, 3'd5);

    // ch3 alone moves rr_ptr to 4
    push(3, 4'd7, 32'h70);
    tick();
    idle();
    tick();
    chk_cdb("rr4 setup", 1'b1, 4'd7, 32'h70, 3'd3);

    // Wrap-around: ch5 before ch0, rr_ptr ends at 1
    push(0, 4'd8, 32'h80);
    push(5, 4'd9, 32'h90);
    tick();
    idle();
    tick();
    chk_cdb("wrap 1st", 1'b1, 4'd9, 32'h90, 3'd5);
    tick();
    chk_cdb("wrap 2nd", 1'b1, 4'd8, 32'h80, 3'd0);

    // rr_ptr should be 1: ch1 beats ch0
    push(0, 4'd4, 32'h40);
    push(1, 4'd6, 32'h61);
    tick();
    idle();
    tick();
    chk_cdb("rr1 1st", 1'b1, 4'd6, 32'h61, 3'd1);
    tick();
    chk_cdb("rr1 2nd", 1'b1, 4'd4, 32'h40, 3'd0);

    // Backpressure on ch0 while ch1..ch3 take their turns first
    push(0, 4'hA, 32'hA0A);
    push(1, 4'd1, 32'h101);
    push(2, 4'd2, 32'h202);
    push(3, 4'd3, 32'h303);
    tick();
    idle();
    push(0, 4'hB, 32'hB0B);
    chk("bp pending A", 64'(pending), 64'h0F);
    tick();
    chk_cdb("bp ch1", 1'b1, 4'd1, 32'h101, 3'd1);
    chk("bp ready0 full", 64'(src_ready[0]), 64'h0);
    chk("bp pending B", 64'(pending), 64'h0D);
    push(0, 4'hC, 32'hC0C);
    tick();
    chk_cdb("bp ch2", 1'b1, 4'd2, 32'h202, 3'd2);
    chk("bp ready0 C", 64'(src_ready[0]), 64'h0);
    tick();
    chk_cdb("bp ch3", 1'b1, 4'd3, 32'h303, 3'd3);
    chk("bp ready0 D", 64'(src_ready[0]), 64'h0);
    tick();
    chk_cdb("bp ch0 A", 1'b1, 4'hA, 32'hA0A, 3'd0);
    chk("bp ready0 E", 64'(src_ready[0]), 64'h1);
    tick();
    idle();
    chk_cdb("bp ch0 B", 1'b1, 4'hB, 32'hB0B, 3'd0);
    chk("bp pending F", 64'(pending), 64'h01);
    tick();
    chk_cdb("bp ch0 C", 1'b1, 4'hC, 32'hC0C, 3'd0);
    chk("bp pending G", 64'(pending), 64'h00);
    tick();
    chk_cdb("bp idle", 1'b0, 4'd0, 32'h0, 3'd0);

    // Tag 0 is handshaken but discarded
    push(4, 4'd0, 32'hDEAD);
    tick();
    chk("tag0 ready", 64'(src_ready[4]), 64'h1);
    chk("tag0 pending", 64'(pending), 64'h00);
    chk_cdb("tag0 E0", 1'b0, 4'd0, 32'h0, 3'd0);
    idle();
    tick();
    chk_cdb("tag0 E1", 1'b0, 4'd0, 32'h0, 3'd0);

    // Flush with four results buffered; a push during flush is also dropped
    push(1, 4'd1, 32'h1);
    push(2, 4'd2, 32'h2);
    push(4, 4'd4, 32'h4);
    push(5, 4'd5, 32'h5);
    tick();
    idle();
    chk("flush pending before", 64'(pending), 64'h36);
    flush = 1'b1;
    push(3, 4'd9, 32'h9);
    tick();
    flush = 1'b0;
    idle();
    chk_cdb("flush E", 1'b0, 4'd0, 32'h0, 3'd0);
    chk("flush pending", 64'(pending), 64'h00);
    chk("flush src_ready", 64'(src_ready), 64'h3F);
    chk("flush tag hold", 64'(cdb_tag), 64'hC);
    tick();
    chk_cdb("flush after", 1'b0, 4'd0, 32'h0, 3'd0);
    push(2, 4'd5, 32'h1234);
    tick();
    idle();
    tick();
    chk_cdb("flush push E1", 1'b1, 4'd5, 32'h1234, 3'd2);
    tick();
    chk_cdb("flush push E2", 1'b0, 4'd0, 32'h0, 3'd0);

    // Reset with four results buffered
    push(0, 4'd1, 32'hA1);
    push(1, 4'd2, 32'hA2);
    push(3, 4'd3, 32'hA3);
    push(4, 4'd4, 32'hA4);
    tick();
    idle();
    chk("rst pending before", 64'(pending), 64'h1B);
    reset = 1'b1;
    tick();
    chk("rst cdb_valid", 64'(cdb_valid), 64'h0);
    chk("rst cdb_tag",   64'(cdb_tag),   64'h0);
    chk("rst cdb_data",  64'(cdb_data),  64'h0);
    chk("rst cdb_src",   64'(cdb_src),   64'h0);
    chk("rst pending",   64'(pending),   64'h00);
    chk("rst src_ready", 64'(src_ready), 64'h00);
    reset = 1'b0;
    #1;
    chk("rst release ready", 64'(src_ready), 64'h3F);
    push(2, 4'd5, 32'h1234);
    tick();
    idle();
    chk_cdb("rst push E0", 1'b0, 4'd0, 32'h0, 3'd0);
    tick();
    chk_cdb("rst push E1", 1'b1, 4'd5, 32'h1234, 3'd2);
    tick();
    chk_cdb("rst push E2", 1'b0, 4'd0, 32'h0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
